// File: rtl/sat_solver_top.sv
`default_nettype none
// ============================================================================
//  Module   : sat_solver_top
//  Purpose  : Streamed-CNF SAT accelerator. Loads clause masks one word per
//             clock, then runs a chronological-backtracking DPLL search with
//             all clauses evaluated in parallel each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module sat_solver_top #(
   parameter int NUM_LITERALS = 30,
   parameter int MAX_CLAUSES  = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic [NUM_LITERALS-1:0] i,
   output logic                    ended,
   output logic                    sat,
   output logic [NUM_LITERALS-1:0] model
);

   localparam int C_CNT_W = $clog2(MAX_CLAUSES + 1);
   localparam int C_IDX_W = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1;

   typedef enum logic [1:0] {
      LOAD_IDLE = 2'd0,
      LOADING   = 2'd1,
      SOLVE     = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t                  r_state;
   logic [C_CNT_W-1:0]      r_count;
   logic                    r_parity;
   logic [NUM_LITERALS-1:0] r_pend;
   logic [NUM_LITERALS-1:0] r_asg;
   logic [NUM_LITERALS-1:0] r_val;
   logic [NUM_LITERALS-1:0] r_flip;
   logic                    r_ended;
   logic                    r_sat;
   logic [NUM_LITERALS-1:0] r_model;

   logic [NUM_LITERALS-1:0] r_pos_mem [MAX_CLAUSES];
   logic [NUM_LITERALS-1:0] r_neg_mem [MAX_CLAUSES];

   logic                    w_full;
   logic                    w_wr_en;
   logic [NUM_LITERALS-1:0] w_wr_neg;
   logic [MAX_CLAUSES-1:0]  w_cconf;
   logic                    w_conflict;
   logic [NUM_LITERALS-1:0] w_bt_cand;
   logic [NUM_LITERALS-1:0] w_bt_hot;
   logic [NUM_LITERALS-1:0] w_bt_below;
   logic                    w_bt_found;
   logic [NUM_LITERALS-1:0] w_next;
   logic                    w_all_asg;

   assign w_full = (r_count == C_CNT_W'(MAX_CLAUSES));

   // A clause is committed when a negative word completes a pair, or when
   // load drops with a positive word still pending (negative mask then 0).
   assign w_wr_en  = (r_state == LOADING) && r_parity && !w_full;
   assign w_wr_neg = load ? i : '0;

   // Clause storage; contents beyond r_count are never looked at.
   always_ff @(posedge clock) begin
      if (w_wr_en) begin
         r_pos_mem[r_count[C_IDX_W-1:0]] <= r_pend;
         r_neg_mem[r_count[C_IDX_W-1:0]] <= w_wr_neg;
      end
   end

   genvar gc;
   for (gc = 0; gc < MAX_CLAUSES; gc++) begin : g_clause
      localparam logic [C_CNT_W-1:0] C_IDX = C_CNT_W'(gc);
      logic w_csat;
      logic w_copen;
      assign w_csat  = (|(r_pos_mem[gc] & r_asg & r_val)) |
                       (|(r_neg_mem[gc] & r_asg & ~r_val));
      assign w_copen = |((r_pos_mem[gc] | r_neg_mem[gc]) & ~r_asg);
      assign w_cconf[gc] = (C_IDX < r_count) && !w_csat && !w_copen;
   end

   assign w_conflict = |w_cconf;

   // Backtrack target: most recent unflipped decision, i.e. the lowest set bit
   // of the assigned-and-unflipped vector (bit 0 is the last variable).
   assign w_bt_cand  = r_asg & ~r_flip;
   assign w_bt_hot   = w_bt_cand & (~w_bt_cand + NUM_LITERALS'(1));
   assign w_bt_below = w_bt_hot - NUM_LITERALS'(1);
   assign w_bt_found = |w_bt_cand;

   // Assigned variables always form a contiguous run from the MSB (x1 first),
   // so the next decision is the bit just below that run.
   assign w_next    = ~r_asg & {1'b1, r_asg[NUM_LITERALS-1:1]};
   assign w_all_asg = &r_asg;

   // Load / solve / done sequencing with registered result outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= LOAD_IDLE;
         r_count  <= '0;
         r_parity <= 1'b0;
         r_pend   <= '0;
         r_asg    <= '0;
         r_val    <= '0;
         r_flip   <= '0;
         r_ended  <= 1'b0;
         r_sat    <= 1'b0;
         r_model  <= '0;
      end else begin
         case (r_state)
            LOAD_IDLE: begin
               if (load) begin
                  r_pend   <= i;
                  r_parity <= 1'b1;
                  r_state  <= LOADING;
               end
            end
            LOADING: begin
               if (load) begin
                  if (!w_full) begin
                     if (!r_parity) begin
                        r_pend   <= i;
                        r_parity <= 1'b1;
                     end else begin
                        r_count  <= r_count + C_CNT_W'(1);
                        r_parity <= 1'b0;
                     end
                  end
               end else begin
                  if (w_wr_en) r_count <= r_count + C_CNT_W'(1);
                  r_parity <= 1'b0;
                  r_asg    <= '0;
                  r_val    <= '0;
                  r_flip   <= '0;
                  r_state  <= SOLVE;
               end
            end
            SOLVE: begin
               if (w_conflict) begin
                  if (w_bt_found) begin
                     r_asg  <= r_asg & ~w_bt_below;
                     r_val  <= (r_val & ~w_bt_below) ^ w_bt_hot;
                     r_flip <= (r_flip & ~w_bt_below) | w_bt_hot;
                  end else begin
                     r_ended <= 1'b1;
                     r_sat   <= 1'b0;
                     r_model <= '0;
                     r_state <= DONE;
                  end
               end else if (w_all_asg) begin
                  r_ended <= 1'b1;
                  r_sat   <= 1'b1;
                  r_model <= r_val;
                  r_state <= DONE;
               end else begin
                  r_asg  <= r_asg | w_next;
                  r_val  <= r_val | w_next;
                  r_flip <= r_flip & ~w_next;
               end
            end
            DONE: begin
               if (load) begin
                  r_ended  <= 1'b0;
                  r_sat    <= 1'b0;
                  r_model  <= '0;
                  r_count  <= '0;
                  r_pend   <= i;
                  r_parity <= 1'b1;
                  r_state  <= LOADING;
               end
            end
            default: r_state <= LOAD_IDLE;
         endcase
      end
   end

   assign ended = r_ended;
   assign sat   = r_sat;
   assign model = r_model;

endmodule
`default_nettype wire

// File: tb/tb_sat_solver_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sat_solver_top
//  Purpose  : Self-checking bench for sat_solver_top with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sat_solver_top;

   localparam int N      = 30;
   localparam int M      = 64;
   localparam int BUDGET = 3000;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         load  = 1'b0;
   logic [N-1:0] i     = '0;
   logic         ended;
   logic         sat;
   logic [N-1:0] model;

   typedef struct packed {
      logic         s;
      logic [N-1:0] m;
      logic [15:0]  lat;
   } exp_t;

   exp_t         sb [$];
   logic [N-1:0] f_words [$];
   int           n_vec = 0;
   int           n_err = 0;

   sat_solver_top #(.NUM_LITERALS(N), .MAX_CLAUSES(M)) dut (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .i     (i),
      .ended (ended),
      .sat   (sat),
      .model (model)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [N-1:0] vbit(input int k);
      logic [N-1:0] one;
      one = 1;
      return one << (N - k);
   endfunction

   task automatic add_clause(input logic [N-1:0] p, input logic [N-1:0] n);
      f_words.push_back(p);
      f_words.push_back(n);
   endtask

   task automatic drive_words();
      @(negedge clock);
      foreach (f_words[k]) begin
         load = 1'b1;
         i    = f_words[k];
         @(negedge clock);
      end
      load = 1'b0;
      i    = '0;
   endtask

   task automatic push_exp(input logic s, input logic [N-1:0] m, input int lat);
      exp_t e;
      e.s   = s;
      e.m   = m;
      e.lat = 16'(lat);
      sb.push_back(e);
   endtask

   // Waits for ended after load falls, then pops and compares one entry.
   task automatic collect(input string tag);
      int   cyc;
      exp_t e;
      cyc = 0;
      do begin
         @(posedge clock);
         #1;
         cyc++;
      end while (!ended && cyc < BUDGET);
      e = sb.pop_front();
      if (!ended) begin
         check({tag, "_timeout"}, 32'(ended), 32'(1));
         return;
      end
      check({tag, "_sat"}, 32'(sat), 32'(e.s));
      check({tag, "_model"}, 32'(model), 32'(e.m));
      if (e.lat != 0) check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
   endtask

   function automatic logic model_ok(input logic [N-1:0] m);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k + 1 < f_words.size(); k += 2) begin
         logic hit;
         hit = 1'b0;
         for (int b = 0; b < N; b++) begin
            if (f_words[k][b] && m[b])    hit = 1'b1;
            if (f_words[k+1][b] && !m[b]) hit = 1'b1;
         end
         if (!hit) ok = 1'b0;
      end
      return ok;
   endfunction

   task automatic run(input string tag, input logic s, input logic [N-1:0] m, input int lat);
      push_exp(s, m, lat);
      drive_words();
      collect(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] h;
      logic [N-1:0] ones;
      ones = '1;

      #12;
      check("rst_ended", 32'(ended), 32'(0));
      check("rst_sat",   32'(sat),   32'(0));
      check("rst_model", 32'(model), 32'(0));
      @(negedge clock);
      reset = 1'b1;

      // (x1)
      f_words.delete();
      add_clause(vbit(1), '0);
      run("x1", 1'b1, ones, N + 2);

      // (x1)(~x1)
      f_words.delete();
      add_clause(vbit(1), '0);
      add_clause('0, vbit(1));
      run("x1_nx1", 1'b0, '0, 0);

      // (~x1): one backtrack more than (x1)
      f_words.delete();
      add_clause('0, vbit(1));
      run("nx1", 1'b1, ones & ~vbit(1), N + 3);

      // (x1 v x2)(~x1 v ~x2)(~x2)
      f_words.delete();
      add_clause(vbit(1) | vbit(2), '0);
      add_clause('0, vbit(1) | vbit(2));
      add_clause('0, vbit(2));
      run("three", 1'b1, ones & ~vbit(2), 0);

      // Chain of equivalences/anti-equivalences with a unique solution h
      h = N'($urandom);
      f_words.delete();
      if (h[N-1]) add_clause(vbit(1), '0); else add_clause('0, vbit(1));
      for (int k = 1; k < N; k++) begin
         if (h[N-k] == h[N-k-1]) begin
            add_clause(vbit(k+1), vbit(k));
            add_clause(vbit(k), vbit(k+1));
         end else begin
            add_clause(vbit(k) | vbit(k+1), '0);
            add_clause('0, vbit(k) | vbit(k+1));
         end
      end
      if (h[0]) add_clause(vbit(N), '0); else add_clause('0, vbit(N));
      run("chain", 1'b1, h, 0);
      check("chain_clauses", 32'(model_ok(model)), 32'(1));

      // Odd word count: single pending positive word (x30)
      f_words.delete();
      f_words.push_back(vbit(N));
      run("odd", 1'b1, ones, 0);

      // Empty clause
      f_words.delete();
      add_clause('0, '0);
      run("empty", 1'b0, '0, 0);

      // Async reset while holding a SAT result
      f_words.delete();
      add_clause(vbit(3), '0);
      run("pre_rst", 1'b1, ones, 0);
      #2 reset = 1'b0;
      #1;
      check("arst_ended", 32'(ended), 32'(0));
      check("arst_sat",   32'(sat),   32'(0));
      check("arst_model", 32'(model), 32'(0));
      @(negedge clock);
      reset = 1'b1;

      // Reset mid-solve must abort the search entirely
      f_words.delete();
      add_clause('0, vbit(N));
      drive_words();
      repeat (5) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("msolve_ended", 32'(ended), 32'(0));
      @(negedge clock);
      reset = 1'b1;
      repeat (2 * N) @(posedge clock);
      #1;
      check("msolve_abort", 32'(ended), 32'(0));

      // Over-capacity: 64 unit clauses, then an empty clause and a stray word
      f_words.delete();
      for (int c = 0; c < M; c++) add_clause(vbit((c % N) + 1), '0);
      add_clause('0, '0);
      f_words.push_back('0);
      run("overflow", 1'b1, ones, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sat_solver_top.md
Name: sat_solver_top

Overview:
Hardware SAT solver top level. It streams a CNF formula in one word per clock, then runs a chronological-backtracking DPLL search and reports SAT/UNSAT plus a satisfying model. All clauses are evaluated in parallel every cycle. It sits as a standalone accelerator, loaded by a host over a simple load/data interface.

Parameters:
NUM_LITERALS, 30 (number_literal from package common), number of variables and width of data and model.
MAX_CLAUSES, 64, clause storage capacity.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
load  in  1  high while formula words are streamed.
i  in  NUM_LITERALS  formula word; bit NUM_LITERALS-1 (MSB) is variable x1, bit 0 is x30.
ended  out  1  search finished; holds until reset or new load.
sat  out  1  valid when ended=1; 1 means satisfiable.
model  out  NUM_LITERALS  satisfying assignment, same bit mapping as i; valid when ended=1 and sat=1, else 0.

Behaviour:
- Reset (reset=0, async): go to LOAD_IDLE; clause count, word parity and assignment cleared; ended=0, sat=0, model=0.
- Clause encoding: two consecutive words. The first is the positive-literal mask and the second the negative-literal mask. Clause = OR of x_k for set positive bits, OR of ~x_k for set negative bits.
- LOAD: on each rising edge with load=1, capture i.
  - Even-numbered word goes to the pending positive mask.
  - Odd-numbered word completes the clause; store it at the current count and increment.
  - Words arriving after MAX_CLAUSES clauses are stored are ignored.
- load 1->0 ends loading.
  - A pending unpaired positive word is stored with negative mask 0.
  - Enter SOLVE on the next edge.
  - If load=1 is seen in DONE, clear storage, ended and sat, and begin a new load with that word.
- Clause evaluation, combinational over stored clauses only:
  - sat_c = |(pos & asg & val) or |(neg & asg & ~val).
  - conflict_c = ~sat_c and ((pos|neg) & ~asg) == 0.
  - An empty clause (pos=neg=0) is therefore always in conflict, making the formula UNSAT.
- SOLVE, one action per cycle:
  - Any conflict: backtrack. Find the highest-index assigned decision variable with flipped=0. Unassign all variables after it, invert its value and set flipped=1. If none exists, go to DONE with sat=0.
  - No conflict and all variables assigned: go to DONE with sat=1.
  - Otherwise: decide the lowest-index unassigned variable (x1 first) with value 1 and flipped=0.
- DONE: ended=1. The model register is loaded with val (0 when UNSAT). Outputs are stable until reset or new load.
- Zero clauses loaded: SAT, model all ones.
- Latency: a conflict-free search ends NUM_LITERALS+2 cycles after load falls. The worst case is exponential, with no timeout.
- ended and sat change only in DONE entry and exit, and never glitch during the search.
- Reset asserted mid-load or mid-solve aborts immediately, and all outputs return to 0.

Test Plan:
1. Load (x1): words 0x20000000 then 0 -> ended=1, sat=1, model=30'h3FFFFFFF.
2. Load (x1),(~x1): words 0x20000000, 0, 0, 0x20000000 -> ended=1, sat=0, model=0.
3. Load (~x1): words 0, 0x20000000 -> sat=1, model=30'h1FFFFFFF. Covers backtrack of x1 and ended asserted exactly 1 backtrack cycle later than case 1.
4. Load (x1 v x2),(~x1 v ~x2),(~x2) -> sat=1, model bit29=1, bit28=0, others 1. Then a 60-clause 30-variable chain formula -> sat=1, and an independent checker confirms model satisfies every clause.
5. Odd word count: a single word 0x00000001, then load low -> clause (x30), sat=1, model bit0=1. An empty pair (0,0) -> sat=0.
6. Drop reset to 0 mid-solve -> ended=0, sat=0, model=0 immediately. A reload then solves correctly; more than 64 clauses -> extra clauses ignored.
